// File: rtl/dut_io_shim.sv
// dut_io_shim
// Stimulus/capture shim placed around the DUT in the simulation harness.
// A word-serial write port stages N_IN input lanes in a shadow buffer.
// A commit applies the whole shadow atomically to the flat DUT input bus.
// After a programmable settle delay the DUT output bus is snapshotted.
// The snapshot is then streamed back one lane per rd_valid/rd_ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_valid/wr_ready     write beat handshake (accepted only while idle)
//   wr_idx, wr_data       target input lane and its data
//   commit                apply staged lanes and start a capture
//   dut_in                flat DUT input bus, lane k at [k*WORD_W +: WORD_W]
//   dut_out               flat DUT output bus, lane k at [k*WORD_W +: WORD_W]
//   rd_valid/rd_ready     capture word handshake
//   rd_data/rd_idx/rd_last captured lane value, its index, final-lane flag
//   done                  one-cycle pulse after the final capture beat
//   busy                  capture in progress
//   err                   sticky: dropped commit or out-of-range wr_idx
//   commit_cnt            number of accepted commits (wraps)
module dut_io_shim #(
  parameter int unsigned       WORD_W     = 32,
  parameter int unsigned       N_IN       = 3,
  parameter int unsigned       N_OUT      = 3,
  parameter int unsigned       SETTLE_CYC = 0,
  parameter logic [WORD_W-1:0] INIT_WORD  = '0,
  localparam int unsigned      IW         = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned      OW         = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IW-1:0]           wr_idx,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic                    commit,
  output logic [N_IN*WORD_W-1:0]  dut_in,
  input  logic [N_OUT*WORD_W-1:0] dut_out,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WORD_W-1:0]       rd_data,
  output logic [OW-1:0]           rd_idx,
  output logic                    rd_last,
  output logic                    done,
  output logic                    busy,
  output logic                    err,
  output logic [31:0]             commit_cnt
);

  localparam logic [7:0] SettleInit = 8'(SETTLE_CYC);

  typedef enum logic [1:0] {StIdle, StSettle, StDrain} state_e;

  state_e                  r_state;
  logic [WORD_W-1:0]       r_shadow [N_IN];
  logic [N_IN*WORD_W-1:0]  r_dut_in;
  logic [WORD_W-1:0]       r_snap [N_OUT];
  logic [OW-1:0]           r_rd_ptr;
  logic [7:0]              r_cnt;
  logic [31:0]             r_commit_cnt;
  logic                    r_err;
  logic                    r_done;

  logic                    w_idle;
  logic                    w_drain;
  logic                    w_wr_inrange;
  logic                    w_last;
  logic [WORD_W-1:0]       w_next_in [N_IN];

  assign w_idle       = (r_state == StIdle);
  assign w_drain      = (r_state == StDrain);
  assign w_wr_inrange = (32'(wr_idx) < N_IN);
  assign w_last       = (r_rd_ptr == OW'(N_OUT - 1));

  // Value applied on commit: the shadow with any same-cycle write folded in.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      w_next_in[k] = r_shadow[k];
    end
    if (w_idle && wr_valid && w_wr_inrange) begin
      w_next_in[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_dut_in     <= {N_IN{INIT_WORD}};
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_commit_cnt <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      for (int k = 0; k < N_IN; k++) begin
        r_shadow[k] <= INIT_WORD;
      end
      for (int k = 0; k < N_OUT; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (wr_valid) begin
            if (w_wr_inrange) begin
              r_shadow[wr_idx] <= wr_data;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (commit) begin
            for (int k = 0; k < N_IN; k++) begin
              r_dut_in[k*WORD_W +: WORD_W] <= w_next_in[k];
            end
            r_commit_cnt <= r_commit_cnt + 32'd1;
            r_cnt        <= SettleInit;
            r_state      <= StSettle;
          end
        end
        StSettle: begin
          if (commit) begin
            r_err <= 1'b1;
          end
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            for (int k = 0; k < N_OUT; k++) begin
              r_snap[k] <= dut_out[k*WORD_W +: WORD_W];
            end
            r_rd_ptr <= '0;
            r_state  <= StDrain;
          end
        end
        StDrain: begin
          if (commit) begin
            r_err <= 1'b1;
          end
          if (rd_ready) begin
            if (w_last) begin
              r_rd_ptr <= '0;
              r_state  <= StIdle;
              r_done   <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + OW'(1);
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Read outputs are forced to zero outside DRAIN so they read as idle.
  assign rd_valid   = w_drain;
  assign rd_data    = w_drain ? r_snap[r_rd_ptr] : '0;
  assign rd_idx     = w_drain ? r_rd_ptr : '0;
  assign rd_last    = w_drain && w_last;
  assign wr_ready   = w_idle;
  assign busy       = !w_idle;
  assign done       = r_done;
  assign err        = r_err;
  assign commit_cnt = r_commit_cnt;
  assign dut_in     = r_dut_in;

endmodule

// File: tb/tb_dut_io_shim.sv
// Directed bench for dut_io_shim.
// Instance u_dut0 uses SETTLE_CYC=0 and a DUT stub of out = in + 1 per lane.
// Its capture beats are checked against a queue of expected words filled at commit time.
// Instance u_dut3 uses SETTLE_CYC=3 with a directly driven dut_out.
// It covers capture timing.
module tb_dut_io_shim;

  localparam logic [31:0] Init0 = 32'h1111_2222;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0 stimulus / observation
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        rd_ready = 1'b0;
  logic        wr_ready0, rd_valid0, rd_last0, done0, busy0, err0;
  logic [95:0] dut_in0, dut_out0;
  logic [31:0] rd_data0, commit_cnt0;
  logic [1:0]  rd_idx0;

  assign dut_out0 = {dut_in0[95:64] + 32'd1, dut_in0[63:32] + 32'd1, dut_in0[31:0] + 32'd1};

  dut_io_shim #(.WORD_W(32), .N_IN(3), .N_OUT(3), .SETTLE_CYC(0), .INIT_WORD(Init0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_idx(wr_idx),
    .wr_data(wr_data), .commit(commit), .dut_in(dut_in0), .dut_out(dut_out0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0), .rd_idx(rd_idx0),
    .rd_last(rd_last0), .done(done0), .busy(busy0), .err(err0), .commit_cnt(commit_cnt0)
  );

  // Instance 3 stimulus / observation
  logic        commit3 = 1'b0;
  logic        rd_ready3 = 1'b0;
  logic [95:0] dut_out3 = 96'h0;
  logic        wr_ready3, rd_valid3, rd_last3, done3, busy3, err3;
  logic [95:0] dut_in3;
  logic [31:0] rd_data3, commit_cnt3;
  logic [1:0]  rd_idx3;

  dut_io_shim #(.WORD_W(32), .N_IN(3), .N_OUT(3), .SETTLE_CYC(3), .INIT_WORD(32'h0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(1'b0), .wr_ready(wr_ready3), .wr_idx(2'd0),
    .wr_data(32'h0), .commit(commit3), .dut_in(dut_in3), .dut_out(dut_out3),
    .rd_valid(rd_valid3), .rd_ready(rd_ready3), .rd_data(rd_data3), .rd_idx(rd_idx3),
    .rd_last(rd_last3), .done(done3), .busy(busy3), .err(err3), .commit_cnt(commit_cnt3)
  );

  // Reference model of instance 0
  logic [31:0] m_shadow [3];
  logic [31:0] m_dut_in [3];
  logic [31:0] m_cnt;
  logic        m_err;
  logic [34:0] sb [$];  // {last, idx, data}

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] m_flat();
    return {m_dut_in[2], m_dut_in[1], m_dut_in[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_shadow[k] = Init0;
      m_dut_in[k] = Init0;
    end
    m_cnt = '0;
    m_err = 1'b0;
    sb.delete();
  endtask

  task automatic model_commit();
    for (int k = 0; k < 3; k++) m_dut_in[k] = m_shadow[k];
    m_cnt = m_cnt + 32'd1;
    for (int k = 0; k < 3; k++) sb.push_back({(k == 2), 2'(k), m_dut_in[k] + 32'd1});
  endtask

  task automatic check_commit();
    chk("commit_dut_in", dut_in0, m_flat());
    chk("commit_cnt", commit_cnt0, m_cnt);
    chk("commit_busy", busy0, 1);
    chk("commit_no_rd_valid", rd_valid0, 0);
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [31:0] data);
    chk("wr_ready", wr_ready0, 1);
    wr_valid = 1'b1; wr_idx = idx; wr_data = data;
    tick();
    wr_valid = 1'b0;
    if (idx < 2'd3) m_shadow[idx] = data;
    else m_err = 1'b1;
    chk("wr_err", err0, m_err);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    model_commit();
    check_commit();
  endtask

  task automatic do_write_commit(input logic [1:0] idx, input logic [31:0] data);
    wr_valid = 1'b1; wr_idx = idx; wr_data = data; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    m_shadow[idx] = data;
    model_commit();
    check_commit();
  endtask

  // Pops expected beats as the DUT presents them; optionally stalls one beat.
  task automatic drain(input int stall_beat, input int stall_len);
    int t = 0;
    int beat = 0;
    logic [34:0] e;
    while (!rd_valid0 && t < 20) begin
      tick();
      t++;
    end
    chk("drain_rd_valid_seen", rd_valid0, 1);
    if (!rd_valid0) begin
      sb.delete();
      return;
    end
    while (sb.size() > 0) begin
      e = sb[0];
      if (beat == stall_beat) begin
        rd_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          chk("stall_data", rd_data0, e[31:0]);
          chk("stall_idx", rd_idx0, e[33:32]);
          chk("stall_done", done0, 0);
        end
      end
      chk("beat_valid", rd_valid0, 1);
      chk("beat_data", rd_data0, e[31:0]);
      chk("beat_idx", rd_idx0, e[33:32]);
      chk("beat_last", rd_last0, e[34]);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      void'(sb.pop_front());
      if (sb.size() > 0) chk("no_early_done", done0, 0);
      beat++;
    end
    chk("done_pulse", done0, 1);
    chk("done_wr_ready", wr_ready0, 1);
    chk("done_rd_valid", rd_valid0, 0);
    tick();
    chk("done_one_cycle", done0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_dut_in", dut_in0, {3{Init0}});
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_rd_idx", rd_idx0, 0);
    chk("rst_rd_last", rd_last0, 0);
    chk("rst_wr_ready", wr_ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_err", err0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cnt", commit_cnt0, 0);
    rst_n = 1'b1;
    tick();

    // Basic pack/unpack with SETTLE_CYC=0
    do_write(2'd0, 32'h0002_0000);
    do_write(2'd1, 32'h0);
    do_write(2'd2, 32'h0);
    do_commit();
    chk("basic_dut_in", dut_in0, 96'h00000000_00000000_00020000);
    tick();
    chk("lat0_rd_valid", rd_valid0, 1);
    drain(-1, 0);
    chk("basic_cnt", commit_cnt0, 1);

    // Backpressure mid-drain
    do_write(2'd2, 32'h0000_0055);
    do_commit();
    drain(1, 5);

    // Commit while busy: ignored, err set
    do_write(2'd0, 32'h0000_0077);
    do_commit();
    chk("busy_err_pre", err0, 0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_err = 1'b1;
    chk("busy_settle_err", err0, 1);
    chk("busy_settle_cnt", commit_cnt0, m_cnt);
    chk("busy_settle_dut_in", dut_in0, m_flat());
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("busy_drain_err", err0, 1);
    chk("busy_drain_cnt", commit_cnt0, m_cnt);
    chk("busy_drain_dut_in", dut_in0, m_flat());
    drain(-1, 0);

    // Same-cycle write + commit, then recommit without writes
    do_write_commit(2'd1, 32'hDEAD_BEEF);
    chk("wc_lane1", dut_in0[63:32], 32'hDEAD_BEEF);
    drain(-1, 0);
    do_commit();
    chk("recommit_same", dut_in0[63:32], 32'hDEAD_BEEF);
    drain(-1, 0);

    // Reset asserted mid-drain
    do_commit();
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid0, 0);
    chk("mid_rst_dut_in", dut_in0, {3{Init0}});
    chk("mid_rst_err", err0, 0);
    chk("mid_rst_cnt", commit_cnt0, 0);
    chk("mid_rst_busy", busy0, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_done", done0, 0);

    // Out-of-range wr_idx sets err and leaves shadow unchanged
    do_write(2'd3, 32'h0BAD_0BAD);
    chk("oor_err", err0, 1);
    do_commit();
    chk("oor_shadow", dut_in0, {3{Init0}});
    chk("post_rst_cnt", commit_cnt0, 1);
    drain(-1, 0);

    // SETTLE_CYC=3 timing on the second instance
    dut_out3 = {32'h0C2, 32'h0C1, 32'h0C0};
    commit3 = 1'b1;
    tick();                                  // E0
    commit3 = 1'b0;
    chk("s3_e0_valid", rd_valid3, 0);
    chk("s3_e0_busy", busy3, 1);
    tick();                                  // E0+1
    chk("s3_e1_valid", rd_valid3, 0);
    tick();                                  // E0+2
    dut_out3 = {32'h0A2, 32'h0A1, 32'h0A0};
    chk("s3_e2_valid", rd_valid3, 0);
    tick();                                  // E0+3
    chk("s3_e3_valid", rd_valid3, 0);
    tick();                                  // E0+4
    chk("s3_e4_valid", rd_valid3, 1);
    chk("s3_beat0", rd_data3, 32'h0A0);
    chk("s3_idx0", rd_idx3, 0);
    dut_out3 = {32'h0B2, 32'h0B1, 32'h0B0};
    rd_ready3 = 1'b1;
    tick();                                  // E0+5
    chk("s3_beat1", rd_data3, 32'h0A1);
    chk("s3_idx1", rd_idx3, 1);
    tick();
    chk("s3_beat2", rd_data3, 32'h0A2);
    chk("s3_last", rd_last3, 1);
    tick();
    rd_ready3 = 1'b0;
    chk("s3_done", done3, 1);
    chk("s3_idle", rd_valid3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dut_io_shim.md
# dut_io_shim

Parametrised stimulus/capture shim between a word-serial harness port and a flat DUT I/O bus. It generalises the fixed three-lane 32-bit pack/unpack wrapper to N_IN input lanes and N_OUT output lanes. It adds three things:
- staged input loading with atomic commit;
- a programmable settle delay;
- snapshot capture of the DUT outputs, streamed back one word per handshake.

It sits directly around the DUT `top` instance in the simulation harness.

## Interface
Parameters:
- WORD_W, 32, lane width in bits
- N_IN, 3, number of DUT input lanes (≥1)
- N_OUT, 3, number of DUT output lanes (≥1)
- SETTLE_CYC, 0, cycles between commit and capture (0..255)
- INIT_WORD, 0, reset value of every dut_in lane

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write beat valid
- wr_ready  out  1  shim accepts write beat
- wr_idx  in  clog2(N_IN) (min 1)  target input lane
- wr_data  in  WORD_W  lane data
- commit  in  1  apply staged lanes to DUT and start a capture
- dut_in  out  N_IN*WORD_W  lane k at [k*WORD_W +: WORD_W]
- dut_out  in  N_OUT*WORD_W  lane k at [k*WORD_W +: WORD_W]
- rd_valid  out  1  capture word valid
- rd_ready  in  1  consumer accepts capture word
- rd_data  out  WORD_W  captured lane value
- rd_idx  out  clog2(N_OUT) (min 1)  lane index of rd_data
- rd_last  out  1  rd_data is lane N_OUT-1
- done  out  1  one-cycle pulse after the final capture beat
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: dropped commit or out-of-range wr_idx
- commit_cnt  out  32  accepted commits, wraps at 2^32

## Operation
- Storage:
  - shadow: N_IN words staging the next stimulus.
  - dut_in register: drives the DUT input bus.
  - snap: N_OUT words holding the captured outputs.
  - rd_ptr: index of the next capture word to emit.
  - settle counter: 8 bit.
- States:
  - IDLE: wr_ready=1, rd_valid=0.
  - SETTLE: wr_ready=0, counter counting down.
  - DRAIN: rd_valid=1, rd_data=snap[rd_ptr], rd_idx=rd_ptr, rd_last=(rd_ptr==N_OUT-1).
- IDLE, wr_valid, wr_idx<N_IN: shadow[wr_idx]←wr_data.
- IDLE, wr_valid, wr_idx≥N_IN: beat is consumed, data is dropped, err←1.
- IDLE, commit: all of the following happen on the same edge.
  - dut_in←shadow.
  - commit_cnt++.
  - counter←SETTLE_CYC.
  - state→SETTLE.
- IDLE, write and commit in the same cycle: the written word is included in the committed value (write-through to dut_in).
- SETTLE, counter≠0: counter--.
- SETTLE, counter==0: snap←dut_out, rd_ptr←0, state→DRAIN.
- DRAIN, rd_valid&&rd_ready, not last: rd_ptr++.
- DRAIN, rd_valid&&rd_ready, last: state→IDLE and done is asserted in the following cycle.
- commit while busy: ignored; err←1; dut_in, shadow and commit_cnt are unchanged.
- wr_valid while busy: not accepted (wr_ready=0); the master holds the beat.
- Shadow persists across commits; only lanes that are written change.
- err clears only on reset.

## Timing
- Reset (asynchronous assert; release synchronous to clk), every output/state value:
  - state=IDLE
  - every dut_in lane and every shadow word = INIT_WORD
  - snap=0, rd_ptr=0
  - commit_cnt=0, err=0, done=0
  - rd_valid=0, rd_data=0, rd_idx=0, rd_last=0
  - wr_ready=1, busy=0
- Commit sampled at edge E0:
  - dut_in changes at E0.
  - snap samples dut_out at edge E0+SETTLE_CYC+1.
  - rd_valid is high from that edge.
- Minimum commit-to-first-rd_valid: 1 cycle (SETTLE_CYC=0).
- Drain takes N_OUT cycles with rd_ready held high. rd_data, rd_idx and rd_last stay stable while rd_valid&&!rd_ready.
- done is high for exactly one cycle, coinciding with the return of wr_ready=1.
  - A commit in that cycle is accepted.
- Reset mid-SETTLE/DRAIN: capture aborts, every output returns to its reset value, and no done pulse is emitted.

## Test plan
- Reset, then write lanes 0..2 = 0x00020000, 0, 0, then commit; DUT stub is out=in+1, SETTLE_CYC=0.
  - Required: dut_in=…00000000_00000000_00020000.
  - Required: rd beats 0x00020001, 0x1, 0x1 with rd_idx 0, 1, 2 and rd_last on idx 2.
  - Required: done one cycle after the last beat; commit_cnt=1.
- SETTLE_CYC=3: commit at edge E0.
  - Required: rd_valid first high after E0+4.
  - Required: a dut_out change at E0+2 is captured, and a change at E0+5 is not.
- Backpressure: hold rd_ready=0 for 5 cycles mid-drain.
  - Required: rd_data/rd_idx stable throughout; no beat lost or duplicated; done only after the final accepted beat.
- Commit pulsed during SETTLE and DRAIN.
  - Required: ignored, err=1, commit_cnt unchanged.
  - Required: wr_idx=N_IN in IDLE also sets err and leaves shadow unchanged.
- Same-cycle wr(idx1, 0xDEADBEEF)+commit.
  - Required: lane 1 of dut_in=0xDEADBEEF at E0.
  - Required: a second commit without writes reapplies identical dut_in.
- rst_n low mid-DRAIN.
  - Required: immediate rd_valid=0, dut_in=INIT_WORD, err=0, commit_cnt=0; the next commit works normally.
